// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two clients over valid/ready handshakes.
// Ports: req0/req1 (valid/ready, a, b, f), rsp0/rsp1 (valid/ready), rsp_y/rsp_zero,
//        alu_a/alu_b/alu_f out to the ALU, alu_y/alu_zero back from it.
// Build option: ALU_ARB_ROUND_ROBIN_EN selects round-robin, otherwise client 0 wins.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_f,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_f,
    output logic              req1_ready,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_f,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_f_q, alu_f_d;
    logic [DATA_W-1:0] rsp_y_q, rsp_y_d;
    logic              rsp_zero_q, rsp_zero_d;

    logic grant0, grant1;
    logic accept;
    logic rsp_take;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // ptr_q names the client preferred on a tie.
    logic ptr_q, ptr_d;

    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~ptr_q);
        grant1 = req1_valid & (~req0_valid | ptr_q);
        ptr_d  = ptr_q;
        if (accept) begin
            ptr_d = grant0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
    end
`endif

    // Readiness is masked during reset so nothing is accepted in that cycle.
    assign req0_ready = (state_q == S_IDLE) & grant0 & ~reset;
    assign req1_ready = (state_q == S_IDLE) & grant1 & ~reset;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign rsp0_valid = (state_q == S_RESP) & ~owner_q & ~reset;
    assign rsp1_valid = (state_q == S_RESP) & owner_q & ~reset;
    assign rsp_take   = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_f_d    = alu_f_q;
        rsp_y_d    = rsp_y_q;
        rsp_zero_d = rsp_zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d = grant1;
                    alu_a_d = grant1 ? req1_a : req0_a;
                    alu_b_d = grant1 ? req1_b : req0_b;
                    alu_f_d = grant1 ? req1_f : req0_f;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_y_d    = alu_y;
                rsp_zero_d = alu_zero;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_take) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_f_q    <= 3'b000;
            rsp_y_q    <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_f_q    <= alu_f_d;
            rsp_y_q    <= rsp_y_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_f    = alu_f_q;
    assign rsp_y    = rsp_y_q;
    assign rsp_zero = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small ALU model.
// Ports: drives both request/response clients, models the shared ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_f, req1_f;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_y;
    logic        rsp_zero;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_f;
    logic [31:0] alu_y;
    logic        alu_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_f(req0_f), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_f(req1_f), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_y(alu_y), .alu_zero(alu_zero)
    );

    // Reference ALU: 000 and, 001 or, 010 add, 110 sub, 111 slt.
    always_comb begin
        alu_y = 32'd0;
        case (alu_f)
            3'b000:  alu_y = alu_a & alu_b;
            3'b001:  alu_y = alu_a | alu_b;
            3'b010:  alu_y = alu_a + alu_b;
            3'b110:  alu_y = alu_a - alu_b;
            3'b111:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = 32'd0;
        endcase
        alu_zero = (alu_y == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    int exp_owner;

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd11; req0_b = 32'd22; req0_f = 3'b010;
        req1_valid = 1'b1; req1_a = 32'd33; req1_b = 32'd44; req1_f = 3'b010;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset for two cycles with both clients valid.
        step();
        settle();
        chk("rst1_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("rst1_rdy1", {31'd0, req1_ready}, 32'd0);
        step();
        settle();
        chk("rst2_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("rst2_rdy1", {31'd0, req1_ready}, 32'd0);
        chk("rst_rspv0", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rspv1", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_rsp_y", rsp_y, 32'd0);
        chk("rst_rsp_z", {31'd0, rsp_zero}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_f", {29'd0, alu_f}, 32'd0);

        // Single add from client 0: 5 + 7.
        reset = 1'b0;
        req0_a = 32'd5; req0_b = 32'd7; req0_f = 3'b010;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        settle();
        chk("add_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("add_rdy1", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        settle();
        chk("add_exec_a", alu_a, 32'd5);
        chk("add_exec_b", alu_b, 32'd7);
        chk("add_exec_f", {29'd0, alu_f}, 32'd2);
        chk("add_exec_rsp", {31'd0, rsp0_valid}, 32'd0);
        step();
        settle();
        chk("add_rspv0", {31'd0, rsp0_valid}, 32'd1);
        chk("add_rspv1", {31'd0, rsp1_valid}, 32'd0);
        chk("add_y", rsp_y, 32'd12);
        chk("add_zero", {31'd0, rsp_zero}, 32'd0);

        // Zero flag from client 1: 9 - 9, issued the cycle IDLE returns.
        step();
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_f = 3'b110;
        rsp1_ready = 1'b1;
        settle();
        chk("add_idle_rsp", {31'd0, rsp0_valid}, 32'd0);
        chk("zf_rdy1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        settle();
        chk("zf_exec_f", {29'd0, alu_f}, 32'd6);
        step();
        settle();
        chk("zf_rspv1", {31'd0, rsp1_valid}, 32'd1);
        chk("zf_rspv0", {31'd0, rsp0_valid}, 32'd0);
        chk("zf_y", rsp_y, 32'd0);
        chk("zf_zero", {31'd0, rsp_zero}, 32'd1);

        // Backpressure: client 0 holds its response; client 1 waits.
        step();
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_f = 3'b010;
        rsp0_ready = 1'b0;
        settle();
        chk("bp_rdy0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd5; req1_f = 3'b110;
        settle();
        chk("bp_exec_rdy1", {31'd0, req1_ready}, 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_hold_v0", {31'd0, rsp0_valid}, 32'd1);
            chk("bp_hold_v1", {31'd0, rsp1_valid}, 32'd0);
            chk("bp_hold_y", rsp_y, 32'd7);
            chk("bp_hold_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
            step();
        end
        rsp0_ready = 1'b1;
        settle();
        chk("bp_rel_v0", {31'd0, rsp0_valid}, 32'd1);
        step();
        settle();
        chk("bp_acc_rdy1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        settle();
        chk("bp_exec_a", alu_a, 32'd20);
        step();
        settle();
        chk("bp_rspv1", {31'd0, rsp1_valid}, 32'd1);
        chk("bp_y1", rsp_y, 32'd15);
        step();

        // Contention: both valid for four ops.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_f = 3'b010;
        req1_valid = 1'b1; req1_a = 32'd8; req1_b = 32'd3; req1_f = 3'b110;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_owner = k % 2;
`else
            exp_owner = 0;
`endif
            settle();
            chk("ct_rdy0", {31'd0, req0_ready}, (exp_owner == 0) ? 32'd1 : 32'd0);
            chk("ct_rdy1", {31'd0, req1_ready}, (exp_owner == 1) ? 32'd1 : 32'd0);
            step();
            step();
            settle();
            chk("ct_rspv0", {31'd0, rsp0_valid}, (exp_owner == 0) ? 32'd1 : 32'd0);
            chk("ct_rspv1", {31'd0, rsp1_valid}, (exp_owner == 1) ? 32'd1 : 32'd0);
            chk("ct_y", rsp_y, (exp_owner == 0) ? 32'd2 : 32'd5);
            step();
        end

        // Reset during EXEC of 1 + 2.
        req1_valid = 1'b0;
        req0_a = 32'd1; req0_b = 32'd2; req0_f = 3'b010;
        settle();
        chk("rm_rdy0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        settle();
        chk("rm_exec_a", alu_a, 32'd1);
        reset = 1'b1;
        settle();
        chk("rm_rst_v0", {31'd0, rsp0_valid}, 32'd0);
        step();
        reset = 1'b0;
        settle();
        chk("rm_post_a", alu_a, 32'd0);
        chk("rm_post_v0", {31'd0, rsp0_valid}, 32'd0);
        chk("rm_post_y", rsp_y, 32'd0);
        req1_valid = 1'b1;
        settle();
        chk("rm_idle_rdy1", {31'd0, req1_ready}, 32'd1);
        req1_valid = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            chk("rm_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit `alu` (operands `a`/`b`, function `f`, result `y`, flag `zero`). It accepts operations from two clients over valid/ready handshakes and grants the ALU to one client at a time. It registers the granted operands onto the ALU inputs and captures `y`/`zero` into a response register, which is held until the owning client acknowledges it. It sits between the instruction/address-generation clients and the single `alu` instance, so the datapath needs only one ALU.

## Interface
- `DATA_W`, 32: operand/result width; must match `alu`.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req0_valid` / `req1_valid`  in  1: client *i* presents an operation.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32: operands.
- `req0_f` / `req1_f`  in  3: ALU function code, passed through unmodified.
- `req0_ready` / `req1_ready`  out  1: operation accepted this cycle when valid & ready.
- `rsp0_valid` / `rsp1_valid`  out  1: result for client *i* is on `rsp_y`/`rsp_zero`.
- `rsp0_ready` / `rsp1_ready`  in  1: client *i* consumes the response.
- `rsp_y`  out  32: captured ALU result.
- `rsp_zero`  out  1: captured ALU `zero` flag.
- `alu_a`, `alu_b`  out  32: registered ALU operands.
- `alu_f`  out  3: registered ALU function.
- `alu_y`  in  32: ALU result.
- `alu_zero`  in  1: ALU zero flag.

## Operation
- **FSM states**
  - IDLE: waits for a request.
  - EXEC: granted operands are driven on `alu_*`.
  - RESP: response is valid and held.
- **IDLE**
  - `reqi_ready = (state==IDLE) & grant_i`.
  - The grant is computed combinationally from the valids and the priority pointer.
  - On handshake: latch the winner's a/b/f into `alu_a/b/f`, record `owner = i`, go to EXEC.
- **EXEC**
  - Lasts exactly one cycle.
  - At its closing edge: `rsp_y <= alu_y`, `rsp_zero <= alu_zero`, go to RESP.
- **RESP**
  - `rsp<owner>_valid = 1`; the other `rsp_valid` is 0.
  - `rsp_y`/`rsp_zero` stay stable.
  - On `rsp<owner>_ready`: go to IDLE.
  - The non-owner's `rsp_ready` is ignored.
- Both `reqi_ready` are 0 outside IDLE; requests are never accepted in EXEC or RESP.
- `alu_a/b/f` keep their values after EXEC until the next grant.
- **Arbitration**
  - A single valid requester is always granted.
  - When both requesters are valid, priority follows the scheme selected under Configuration.
  - Exactly one grant is issued per accept.
- The block does not inspect or decode `f`; every 3-bit code is forwarded to the ALU.

## Timing
- Reset values:
  - State IDLE, `owner = 0`, priority pointer = client 0.
  - All `rsp*_valid = 0`, `rsp_y = 0`, `rsp_zero = 0`.
  - `alu_a = 0`, `alu_b = 0`, `alu_f = 3'b000`.
- Latency and throughput:
  - Accept at edge T, EXEC during cycle T+1, `rsp_valid` high from cycle T+2.
  - A response consumed in its first valid cycle returns the block to IDLE at T+3.
  - Peak throughput is 1 op per 3 cycles.
- `rsp_ready` already high when RESP is entered: one-cycle RESP.
- A request dropped before its handshake is never executed; the valid signal may be deasserted freely while ready is low.
- Reset in EXEC or RESP: the operation and response are discarded, the next cycle is IDLE with reset values, and no `rsp_valid` pulse is produced.
- Reset with requests present: nothing is accepted in the reset cycle.

## Configuration
- Macro: `ALU_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration.
  - A 1-bit pointer names the preferred client.
  - On each accept, the pointer moves to the client that was not granted.
  - On simultaneous requests, the preferred client wins.
- **Undefined:** fixed priority.
  - Client 0 always wins over client 1.
  - No pointer register exists.
  - Client 1 is served only when `req0_valid` is 0 in IDLE.

## Test plan
- **Reset values:** Reset for 2 cycles with both clients valid -> all outputs at reset values and no `reqi_ready` during reset; first accept goes to client 0 in the cycle after reset.
- **Single add:** Client 0 sends a=5, b=7, f=3'b010, with `rsp0_ready` held high -> `req0_ready` at T, `alu_a=5` in T+1, `rsp0_valid` with `rsp_y=12`, `rsp_zero=0` at T+2, IDLE at T+3.
- **Zero flag:** Client 1 sends a=9, b=9, f=3'b110 -> `rsp1_valid` with `rsp_y=0`, `rsp_zero=1`, and `rsp0_valid` stays 0.
- **Response backpressure:** Hold `rsp0_ready=0` for 5 cycles in RESP -> `rsp_y` stable, both `reqi_ready=0` while client 1 is valid; release -> client 1 is accepted in the next cycle.
- **Contention:** Both clients continuously valid for 4 ops -> with `ALU_ARB_ROUND_ROBIN_EN` the grants run 0,1,0,1; without it, 0,0,0,0.
- **Reset mid-operation:** Assert reset during EXEC of a=1, b=2 -> no `rsp_valid` pulse follows, the state is IDLE, and `alu_a=0` in the cycle after reset.
